// File: rtl/window_pkg.sv
// Shared types and helpers for the window detector.
//   win_state_t : match FSM state (outside / inside the window)
//   cnt_width() : width of the debounce counter for a given DEBOUNCE
package window_pkg;

   typedef enum logic [0:0] {
      ST_OUT,
      ST_IN
   } win_state_t;

   // Wide enough to hold DEBOUNCE-1, with a spare bit so DEBOUNCE=1 still gets one bit.
   function automatic int unsigned cnt_width(input int unsigned debounce);
      return $clog2(debounce) + 1;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch synchroniser and whole-vector debouncer.
//   clk        in   1      system clock
//   rst        in   1      synchronous, active-high reset
//   sw         in   WIDTH  raw asynchronous switch inputs
//   stable_val out  WIDTH  value accepted after DEBOUNCE stable cycles
module sw_debounce
   import window_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEBOUNCE = 65536
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] stable_val
);

   localparam int unsigned    CntW   = cnt_width(DEBOUNCE);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

   logic [WIDTH-1:0] s1_q, s_q;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] stable_q, stable_d;

   // Any bit change restarts the count; once the count reaches its ceiling it holds,
   // and the candidate is re-accepted every cycle while it stays put.
   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (s_q != cand_q) begin
         cand_d = s_q;
         cnt_d  = '0;
      end else if (cnt_q < CntMax) begin
         cnt_d = cnt_q + CntW'(1);
      end else begin
         stable_d = cand_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= '0;
         s_q      <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         s1_q     <= sw;
         s_q      <= s1_q;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_val = stable_q;

endmodule

// File: rtl/window_detect.sv
// Registered range detector for the switch bank: debounced value tested against the
// inclusive window [LO, HI] (optionally inverted), driving the LED plus edge pulses and
// a saturating entry count.
//   clk        in   1      system clock
//   rst        in   1      synchronous, active-high reset
//   sw         in   WIDTH  raw asynchronous switch inputs
//   led        out  1      registered window-match indicator
//   enter_p    out  1      one-cycle pulse on led 0->1
//   exit_p     out  1      one-cycle pulse on led 1->0
//   entries    out  CNT_W  saturating count of enter_p pulses
//   stable_val out  WIDTH  current debounced value
module window_detect
   import window_pkg::*;
#(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] LO       = WIDTH'(128),
   parameter logic [WIDTH-1:0] HI       = WIDTH'(154),
   parameter int unsigned      DEBOUNCE = 65536,
   parameter bit               INVERT   = 1'b0,
   parameter int unsigned      CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   output logic             led,
   output logic             enter_p,
   output logic             exit_p,
   output logic [CNT_W-1:0] entries,
   output logic [WIDTH-1:0] stable_val
);

   win_state_t       state_q, state_d;
   logic             led_q, led_d;
   logic             enter_q, enter_d;
   logic             exit_q, exit_d;
   logic [CNT_W-1:0] entries_q, entries_d;
   logic [WIDTH-1:0] val;
   logic             in_win;
   logic             m;

   sw_debounce #(
      .WIDTH    (WIDTH),
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .sw         (sw),
      .stable_val (val)
   );

   // LO > HI leaves no value satisfying both terms, so the window is empty.
   assign in_win = (val >= LO) && (val <= HI);
   assign m      = in_win ^ INVERT;

   always_comb begin
      state_d   = state_q;
      led_d     = led_q;
      enter_d   = 1'b0;
      exit_d    = 1'b0;
      entries_d = entries_q;
      unique case (state_q)
         ST_OUT: begin
            if (m) begin
               state_d = ST_IN;
               led_d   = 1'b1;
               enter_d = 1'b1;
               if (!(&entries_q)) begin
                  entries_d = entries_q + CNT_W'(1);
               end
            end
         end
         ST_IN: begin
            if (!m) begin
               state_d = ST_OUT;
               led_d   = 1'b0;
               exit_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_OUT;
            led_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_OUT;
         led_q     <= 1'b0;
         enter_q   <= 1'b0;
         exit_q    <= 1'b0;
         entries_q <= '0;
      end else begin
         state_q   <= state_d;
         led_q     <= led_d;
         enter_q   <= enter_d;
         exit_q    <= exit_d;
         entries_q <= entries_d;
      end
   end

   assign led        = led_q;
   assign enter_p    = enter_q;
   assign exit_p     = exit_q;
   assign entries    = entries_q;
   assign stable_val = val;

endmodule

// File: tb/tb_window_detect.sv
// Directed bench for window_detect: three instances share clk/rst.
//   dut0: LO=128 HI=154 DEBOUNCE=4 INVERT=0 CNT_W=2 (main tests)
//   dut1: same window, INVERT=1
//   dut2: LO=0 HI=10, reset value 0 lies inside
module tb_window_detect;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] sw0 = 8'h00;
   logic [7:0] sw1 = 8'h00;
   logic [7:0] sw2 = 8'h00;

   logic       led0, en0, ex0;
   logic [1:0] ent0;
   logic [7:0] st0;
   logic       led1, en1, ex1;
   logic [1:0] ent1;
   logic [7:0] st1;
   logic       led2, en2, ex2;
   logic [1:0] ent2;
   logic [7:0] st2;

   int total = 0;
   int bad   = 0;
   logic [7:0] prev0;

   always #5 clk = ~clk;

   window_detect #(
      .WIDTH(8), .LO(8'd128), .HI(8'd154), .DEBOUNCE(4), .INVERT(1'b0), .CNT_W(2)
   ) dut0 (
      .clk(clk), .rst(rst), .sw(sw0), .led(led0), .enter_p(en0), .exit_p(ex0),
      .entries(ent0), .stable_val(st0)
   );

   window_detect #(
      .WIDTH(8), .LO(8'd128), .HI(8'd154), .DEBOUNCE(4), .INVERT(1'b1), .CNT_W(2)
   ) dut1 (
      .clk(clk), .rst(rst), .sw(sw1), .led(led1), .enter_p(en1), .exit_p(ex1),
      .entries(ent1), .stable_val(st1)
   );

   window_detect #(
      .WIDTH(8), .LO(8'd0), .HI(8'd10), .DEBOUNCE(4), .INVERT(1'b0), .CNT_W(2)
   ) dut2 (
      .clk(clk), .rst(rst), .sw(sw2), .led(led2), .enter_p(en2), .exit_p(ex2),
      .entries(ent2), .stable_val(st2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply a new value to dut0 and check the debounce/led timeline from the change.
   task automatic step0(input logic [7:0] v, input logic exp_led, input logic exp_en,
                        input logic exp_ex, input logic [1:0] exp_ent);
      sw0 = v;
      repeat (6) tick();
      chk("hold_prev", {24'h0, st0}, {24'h0, prev0});
      tick();
      chk("stable_e7", {24'h0, st0}, {24'h0, v});
      tick();
      chk("led_e8", {31'h0, led0}, {31'h0, exp_led});
      chk("enter_e8", {31'h0, en0}, {31'h0, exp_en});
      chk("exit_e8", {31'h0, ex0}, {31'h0, exp_ex});
      chk("entries_e8", {30'h0, ent0}, {30'h0, exp_ent});
      tick();
      chk("enter_e9", {31'h0, en0}, 32'h0);
      chk("exit_e9", {31'h0, ex0}, 32'h0);
      prev0 = v;
   endtask

   initial begin
      // Test 1: reset then 0x80 held
      rst = 1'b1;
      sw0 = 8'h80;
      sw1 = 8'h10;
      sw2 = 8'h00;
      repeat (3) tick();
      chk("rst_led", {31'h0, led0}, 32'h0);
      chk("rst_enter", {31'h0, en0}, 32'h0);
      chk("rst_entries", {30'h0, ent0}, 32'h0);
      chk("rst_stable", {24'h0, st0}, 32'h0);
      rst = 1'b0;
      tick();                                        // edge 1
      chk("lo0_enter_e1", {31'h0, en2}, 32'h1);
      chk("lo0_entries_e1", {30'h0, ent2}, 32'h1);
      chk("inv_enter_e1", {31'h0, en1}, 32'h1);
      chk("inv_led_e1", {31'h0, led1}, 32'h1);
      chk("t1_led_e1", {31'h0, led0}, 32'h0);
      tick();                                        // edge 2
      chk("lo0_enter_e2", {31'h0, en2}, 32'h0);
      repeat (4) tick();                             // edge 6
      chk("t1_stable_e6", {24'h0, st0}, 32'h0);
      tick();                                        // edge 7
      chk("t1_stable_e7", {24'h0, st0}, 32'h80);
      chk("t1_led_e7", {31'h0, led0}, 32'h0);
      chk("inv_stable_e7", {24'h0, st1}, 32'h10);
      tick();                                        // edge 8
      chk("t1_led_e8", {31'h0, led0}, 32'h1);
      chk("t1_enter_e8", {31'h0, en0}, 32'h1);
      chk("t1_entries_e8", {30'h0, ent0}, 32'h1);
      chk("inv_led_e8", {31'h0, led1}, 32'h1);
      tick();                                        // edge 9
      chk("t1_enter_e9", {31'h0, en0}, 32'h0);
      chk("t1_led_e9", {31'h0, led0}, 32'h1);
      prev0 = 8'h80;

      // Test 2: window bounds
      step0(8'h9A, 1'b1, 1'b0, 1'b0, 2'd1);
      step0(8'h9B, 1'b0, 1'b0, 1'b1, 2'd1);
      step0(8'h7F, 1'b0, 1'b0, 1'b0, 2'd1);
      step0(8'h80, 1'b1, 1'b1, 1'b0, 2'd2);

      // Test 4: entry counter saturation over five excursions
      sw0 = 8'h00;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      prev0 = 8'h00;
      chk("t4_rst_entries", {30'h0, ent0}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step0(8'h85, 1'b1, 1'b1, 1'b0, (i < 3) ? 2'(i + 1) : 2'd3);
         step0(8'h00, 1'b0, 1'b0, 1'b1, (i < 3) ? 2'(i + 1) : 2'd3);
      end

      // Test 3: bounce shorter than the debounce window
      for (int i = 0; i < 10; i++) begin
         sw0 = (i % 2 == 0) ? 8'h85 : 8'h00;
         repeat (2) begin
            tick();
            chk("t3_stable", {24'h0, st0}, 32'h0);
            chk("t3_led", {31'h0, led0}, 32'h0);
            chk("t3_enter", {31'h0, en0}, 32'h0);
         end
      end
      sw0 = 8'h00;
      repeat (10) begin
         tick();
         chk("t3_hold_stable", {24'h0, st0}, 32'h0);
         chk("t3_hold_led", {31'h0, led0}, 32'h0);
      end
      chk("t3_entries", {30'h0, ent0}, 32'h3);

      // Test 6: reset mid-debounce while IN
      step0(8'h90, 1'b1, 1'b1, 1'b0, 2'd3);
      sw0 = 8'h85;
      repeat (5) tick();                             // debounce count now 2
      rst = 1'b1;
      sw0 = 8'h90;
      tick();
      chk("t6_rst_led", {31'h0, led0}, 32'h0);
      chk("t6_rst_enter", {31'h0, en0}, 32'h0);
      chk("t6_rst_exit", {31'h0, ex0}, 32'h0);
      chk("t6_rst_entries", {30'h0, ent0}, 32'h0);
      chk("t6_rst_stable", {24'h0, st0}, 32'h0);
      chk("t6_rst_inv_led", {31'h0, led1}, 32'h0);
      rst = 1'b0;
      repeat (7) tick();                             // edge 7
      chk("t6_stable_e7", {24'h0, st0}, 32'h90);
      chk("t6_led_e7", {31'h0, led0}, 32'h0);
      tick();                                        // edge 8
      chk("t6_enter_e8", {31'h0, en0}, 32'h1);
      chk("t6_led_e8", {31'h0, led0}, 32'h1);
      chk("t6_entries_e8", {30'h0, ent0}, 32'h1);
      tick();
      chk("t6_enter_e9", {31'h0, en0}, 32'h0);

      // Test 5: inverted window on dut1 (0x10 outside -> led on; 0x90 inside -> off)
      chk("t5_led_pre", {31'h0, led1}, 32'h1);
      chk("t5_entries_pre", {30'h0, ent1}, 32'h1);
      sw1 = 8'h90;
      repeat (7) tick();
      chk("t5_stable_e7", {24'h0, st1}, 32'h90);
      chk("t5_led_e7", {31'h0, led1}, 32'h1);
      tick();
      chk("t5_led_e8", {31'h0, led1}, 32'h0);
      chk("t5_exit_e8", {31'h0, ex1}, 32'h1);
      chk("t5_enter_e8", {31'h0, en1}, 32'h0);
      tick();
      chk("t5_exit_e9", {31'h0, ex1}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
